// File: rtl/zetas_addr_gen.sv
// Twiddle-address sequencer for the NTT unit: walks every butterfly layer of a
// Kyber or Dilithium (inverse) NTT and emits zetas ROM addresses and coefficient indices.
module zetas_addr_gen #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LAYER_GAP  = 0
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    input  logic                  selKD_i,
    input  logic                  selNTT_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic                  selKD_o,
    output logic                  selNTT_o,
    output logic [ADDR_WIDTH-1:0] addrX_o,
    output logic [ADDR_WIDTH-1:0] addrY_o,
    output logic [ADDR_WIDTH-1:0] coefX_o,
    output logic [ADDR_WIDTH-1:0] coefY_o,
    output logic [2:0]            layer_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        kyber_q, kyber_d;
    logic        ntt_q, ntt_d;
    logic [2:0]  layer_q, layer_d;
    logic [6:0]  beat_q, beat_d;
    logic [3:0]  gap_q, gap_d;
    logic        valid_d, busy_d, done_d;
    logic        last_beat, last_layer;
    logic [2:0]  next_layer;
    logic [6:0]  n_x, n_y;
    logic [ADDR_WIDTH-1:0] addr_x_d, addr_y_d, coef_x_d, coef_y_d;

    // Zeta index: forward walks 2^s + g, inverse walks the same table backwards.
    function automatic logic [ADDR_WIDTH-1:0] zeta_idx(input logic [6:0] n,
                                                        input logic [2:0] s,
                                                        input logic       fwd);
        logic [8:0] grp;
        logic [8:0] base;
        grp  = {2'b00, n >> (3'd7 - s)};
        base = 9'd1 << s;
        if (fwd)
            zeta_idx = ADDR_WIDTH'(base + grp);
        else
            zeta_idx = ADDR_WIDTH'((base << 1) - 9'd1 - grp);
    endfunction

    // Lower coefficient index: butterfly number with a 0 inserted at bit 7-s.
    function automatic logic [ADDR_WIDTH-1:0] coef_idx(input logic [6:0] n,
                                                        input logic [2:0] s);
        logic [15:0] hi;
        logic [15:0] lo;
        logic [15:0] mask;
        hi       = {9'd0, n >> (3'd7 - s)} << (4'd8 - {1'b0, s});
        mask     = (16'd128 >> s) - 16'd1;
        lo       = {9'd0, n} & mask;
        coef_idx = ADDR_WIDTH'(hi | lo);
    endfunction

    assign last_beat  = (beat_q == (kyber_q ? 7'd63 : 7'd127));
    assign last_layer = ntt_q ? (layer_q == (kyber_q ? 3'd6 : 3'd7)) : (layer_q == 3'd0);
    assign next_layer = ntt_q ? (layer_q + 3'd1) : (layer_q - 3'd1);

    always_comb begin
        state_d = state_q;
        kyber_d = kyber_q;
        ntt_d   = ntt_q;
        layer_d = layer_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    kyber_d = selKD_i;
                    ntt_d   = selNTT_i;
                    layer_d = selNTT_i ? 3'd0 : (selKD_i ? 3'd6 : 3'd7);
                    beat_d  = '0;
                    state_d = ST_RUN;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                busy_d  = 1'b1;
                valid_d = 1'b1;
                if (valid_o && ready_i) begin
                    if (last_beat) begin
                        beat_d = '0;
                        if (last_layer) begin
                            state_d = ST_DONE;
                            valid_d = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            layer_d = next_layer;
                            if (LAYER_GAP != 0) begin
                                state_d = ST_GAP;
                                gap_d   = '0;
                                valid_d = 1'b0;
                            end
                        end
                    end else begin
                        beat_d = beat_q + 7'd1;
                    end
                end
            end
            ST_GAP: begin
                busy_d = 1'b1;
                if ({28'd0, gap_q} + 32'd1 >= LAYER_GAP) begin
                    state_d = ST_RUN;
                    valid_d = 1'b1;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Kyber pairs butterfly b (lane X) with b+64 (lane Y); Dilithium uses lane Y only.
        n_x      = {1'b0, beat_d[5:0]};
        n_y      = kyber_d ? {1'b1, beat_d[5:0]} : beat_d;
        addr_x_d = (valid_d && kyber_d) ? zeta_idx(n_x, layer_d, ntt_d) : '0;
        coef_x_d = (valid_d && kyber_d) ? coef_idx(n_x, layer_d) : '0;
        addr_y_d = valid_d ? zeta_idx(n_y, layer_d, ntt_d) : '0;
        coef_y_d = valid_d ? coef_idx(n_y, layer_d) : '0;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= ST_IDLE;
            kyber_q  <= 1'b0;
            ntt_q    <= 1'b0;
            layer_q  <= '0;
            beat_q   <= '0;
            gap_q    <= '0;
            valid_o  <= 1'b0;
            selKD_o  <= 1'b0;
            selNTT_o <= 1'b0;
            addrX_o  <= '0;
            addrY_o  <= '0;
            coefX_o  <= '0;
            coefY_o  <= '0;
            layer_o  <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            state_q  <= state_d;
            kyber_q  <= kyber_d;
            ntt_q    <= ntt_d;
            layer_q  <= layer_d;
            beat_q   <= beat_d;
            gap_q    <= gap_d;
            valid_o  <= valid_d;
            selKD_o  <= busy_d & kyber_d;
            selNTT_o <= busy_d & ntt_d;
            addrX_o  <= addr_x_d;
            addrY_o  <= addr_y_d;
            coefX_o  <= coef_x_d;
            coefY_o  <= coef_y_d;
            layer_o  <= busy_d ? layer_d : 3'd0;
            busy_o   <= busy_d;
            done_o   <= done_d;
        end
    end

endmodule

// File: tb/tb_zetas_addr_gen.sv
// Self-checking bench for zetas_addr_gen: spot-check vector table plus a
// per-beat arithmetic reference model under fixed, stalled and random back-pressure.
module tb_zetas_addr_gen;

    logic       clk;
    logic       rstn;
    logic       start0, start1;
    logic       sel_kd, sel_ntt, ready;
    logic       o0_valid, o0_kd, o0_ntt, o0_busy, o0_done;
    logic       o1_valid, o1_kd, o1_ntt, o1_busy, o1_done;
    logic [7:0] o0_ax, o0_ay, o0_cx, o0_cy, o1_ax, o1_ay, o1_cx, o1_cy;
    logic [2:0] o0_layer, o1_layer;

    bit         use_gap;
    logic       obs_valid, obs_kd, obs_ntt, obs_busy, obs_done;
    logic [7:0] obs_ax, obs_ay, obs_cx, obs_cy;
    logic [2:0] obs_layer;

    int n_compared;
    int n_mismatched;
    int busy_cycles;

    logic [63:0] exp_q[$];
    logic [63:0] seen[$];

    typedef struct packed {
        bit kyber;
        bit ntt;
        bit gap_dut;
        int beat;
        int ax;
        int ay;
        int cx;
        int cy;
        int layer;
    } vec_t;
    vec_t vecs[$];

    zetas_addr_gen #(.ADDR_WIDTH(8), .LAYER_GAP(0)) dut0 (
        .clk_i(clk), .rstn_i(rstn), .start_i(start0), .selKD_i(sel_kd),
        .selNTT_i(sel_ntt), .ready_i(ready), .valid_o(o0_valid), .selKD_o(o0_kd),
        .selNTT_o(o0_ntt), .addrX_o(o0_ax), .addrY_o(o0_ay), .coefX_o(o0_cx),
        .coefY_o(o0_cy), .layer_o(o0_layer), .busy_o(o0_busy), .done_o(o0_done)
    );

    zetas_addr_gen #(.ADDR_WIDTH(8), .LAYER_GAP(2)) dut1 (
        .clk_i(clk), .rstn_i(rstn), .start_i(start1), .selKD_i(sel_kd),
        .selNTT_i(sel_ntt), .ready_i(ready), .valid_o(o1_valid), .selKD_o(o1_kd),
        .selNTT_o(o1_ntt), .addrX_o(o1_ax), .addrY_o(o1_ay), .coefX_o(o1_cx),
        .coefY_o(o1_cy), .layer_o(o1_layer), .busy_o(o1_busy), .done_o(o1_done)
    );

    assign obs_valid = use_gap ? o1_valid : o0_valid;
    assign obs_kd    = use_gap ? o1_kd    : o0_kd;
    assign obs_ntt   = use_gap ? o1_ntt   : o0_ntt;
    assign obs_busy  = use_gap ? o1_busy  : o0_busy;
    assign obs_done  = use_gap ? o1_done  : o0_done;
    assign obs_ax    = use_gap ? o1_ax    : o0_ax;
    assign obs_ay    = use_gap ? o1_ay    : o0_ay;
    assign obs_cx    = use_gap ? o1_cx    : o0_cx;
    assign obs_cy    = use_gap ? o1_cy    : o0_cy;
    assign obs_layer = use_gap ? o1_layer : o0_layer;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pack_beat(int ax, int ay, int cx, int cy, int layer,
                                              bit kd, bit ntt, bit busy, bit valid);
        return {24'd0, 8'(ax), 8'(ay), 8'(cx), 8'(cy), 4'(layer), kd, ntt, busy, valid};
    endfunction

    function automatic logic [63:0] obs_pack();
        return pack_beat(int'(obs_ax), int'(obs_ay), int'(obs_cx), int'(obs_cy),
                         int'(obs_layer), obs_kd, obs_ntt, obs_busy, obs_valid);
    endfunction

    // Reference arithmetic: a layer of span len groups butterflies in blocks of len.
    function automatic int model_zeta(int n, int s, bit ntt);
        int g;
        g = n / (128 >> s);
        return ntt ? ((1 << s) + g) : ((1 << (s + 1)) - 1 - g);
    endfunction

    function automatic int model_coef(int n, int s);
        int len;
        len = 128 >> s;
        return (n / len) * 2 * len + (n % len);
    endfunction

    function automatic void build_model(bit kyber, bit ntt);
        int n_layers, n_beats, s, ax, cx, ny;
        exp_q.delete();
        n_layers = kyber ? 7 : 8;
        n_beats  = kyber ? 64 : 128;
        for (int k = 0; k < n_layers; k++) begin
            s = ntt ? k : (n_layers - 1 - k);
            for (int b = 0; b < n_beats; b++) begin
                ax = kyber ? model_zeta(b, s, ntt) : 0;
                cx = kyber ? model_coef(b, s) : 0;
                ny = kyber ? b + 64 : b;
                exp_q.push_back(pack_beat(ax, model_zeta(ny, s, ntt), cx, model_coef(ny, s),
                                          s, kyber, ntt, 1'b1, 1'b1));
            end
        end
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic drive_start(input bit gap_dut, input logic v);
        if (gap_dut) start1 = v;
        else         start0 = v;
    endtask

    // Runs one whole transform, checking every beat against the model as it is offered.
    task automatic applyStimulus(input bit kyber, input bit ntt, input bit gap_dut,
                                 input bit rand_ready, input int stall_at, input int stall_len,
                                 input int poke_at, input bit start_at_done);
        int idx, cycles, stalls, gap_run, stall_left, gap_len, n_layers;
        bit finished, poked, rdy;
        use_gap    = gap_dut;
        gap_len    = gap_dut ? 2 : 0;
        n_layers   = kyber ? 7 : 8;
        build_model(kyber, ntt);
        seen.delete();
        idx = 0; cycles = 0; stalls = 0; gap_run = 0; stall_left = stall_len;
        finished = 1'b0; poked = 1'b0; busy_cycles = 0;
        @(negedge clk);
        sel_kd = kyber; sel_ntt = ntt; ready = 1'b1;
        drive_start(gap_dut, 1'b1);
        @(negedge clk);
        drive_start(gap_dut, 1'b0);
        while (!finished && cycles < 4000) begin
            cycles++;
            if (idx == exp_q.size()) begin
                checkOutput("done pulse {done,busy,valid}", {obs_done, obs_busy, obs_valid}, 3'b100);
                if (start_at_done) drive_start(gap_dut, 1'b1);
                @(negedge clk);
                drive_start(gap_dut, 1'b0);
                checkOutput("after done {done,busy,valid}", {obs_done, obs_busy, obs_valid}, 3'b000);
                finished = 1'b1;
            end else begin
                if (obs_busy) busy_cycles++;
                if (obs_valid) begin
                    if (gap_run > 0) begin
                        checkOutput("gap length", gap_run, gap_len);
                        gap_run = 0;
                    end
                    checkOutput($sformatf("beat %0d", idx), obs_pack(), exp_q[idx]);
                    if (stall_at == idx && stall_left > 0) begin
                        rdy = 1'b0;
                        stall_left--;
                    end else if (rand_ready) begin
                        rdy = ($urandom_range(0, 3) != 0);
                    end else begin
                        rdy = 1'b1;
                    end
                    if (!rdy) stalls++;
                    ready = rdy;
                    if (rdy) begin
                        seen.push_back(obs_pack());
                        idx++;
                    end
                end else if (obs_busy) begin
                    gap_run++;
                end else begin
                    checkOutput($sformatf("busy at beat %0d", idx), obs_busy, 1);
                    finished = 1'b1;
                end
                if (poke_at >= 0 && idx == poke_at && !poked) begin
                    drive_start(gap_dut, 1'b1);
                    sel_kd = !kyber; sel_ntt = !ntt;
                    poked = 1'b1;
                end else begin
                    drive_start(gap_dut, 1'b0);
                end
                if (!finished) @(negedge clk);
            end
        end
        ready = 1'b1;
        checkOutput("finished within budget", finished, 1);
        checkOutput("busy cycles", busy_cycles, exp_q.size() + stalls + gap_len * (n_layers - 1));
    endtask

    task automatic checkTable(input bit kyber, input bit ntt, input bit gap_dut);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].kyber == kyber && vecs[i].ntt == ntt && vecs[i].gap_dut == gap_dut) begin
                if (vecs[i].beat < seen.size())
                    checkOutput($sformatf("vector %0d beat %0d", i, vecs[i].beat), seen[vecs[i].beat],
                                pack_beat(vecs[i].ax, vecs[i].ay, vecs[i].cx, vecs[i].cy,
                                          vecs[i].layer, kyber, ntt, 1'b1, 1'b1));
                else
                    checkOutput($sformatf("vector %0d beats seen", i), seen.size(), vecs[i].beat + 1);
            end
        end
    endtask

    initial begin
        int waited;
        n_compared = 0; n_mismatched = 0;
        rstn = 1'b0; start0 = 1'b0; start1 = 1'b0;
        sel_kd = 1'b0; sel_ntt = 1'b0; ready = 1'b1; use_gap = 1'b0;

        // {kyber, ntt, gap_dut, beat, addrX, addrY, coefX, coefY, layer}
        vecs.push_back('{1'b1, 1'b1, 1'b0, 0,    1,   1,   0,   64,  0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 64,   2,   3,   0,   128, 1});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 447,  95,  127, 125, 253, 6});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 0,    0,   255, 0,   0,   7});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1,    0,   254, 0,   2,   7});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1023, 0,   1,   0,   127, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 10,   0,   1,   0,   10,  0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 0,    127, 95,  0,   128, 6});

        #12;
        checkOutput("reset state dut0", obs_pack(), 64'd0);
        checkOutput("reset done dut0", obs_done, 0);
        use_gap = 1'b1;
        #1;
        checkOutput("reset state dut1", obs_pack(), 64'd0);
        use_gap = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        $display("[TB] Kyber NTT, no stalls");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, -1, 0, -1, 1'b0);
        checkOutput("Kyber NTT busy cycles", busy_cycles, 448);
        checkTable(1'b1, 1'b1, 1'b0);

        $display("[TB] Dilithium InvNTT, start held at done");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, -1, 0, -1, 1'b1);
        checkOutput("Dilithium InvNTT busy cycles", busy_cycles, 1024);
        checkTable(1'b0, 1'b0, 1'b0);

        $display("[TB] Dilithium NTT, 5-cycle stall at beat 10");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10, 5, -1, 1'b0);
        checkOutput("stalled busy cycles", busy_cycles, 1029);
        checkTable(1'b0, 1'b1, 1'b0);

        $display("[TB] Kyber InvNTT with 2-cycle layer gap");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, -1, 0, -1, 1'b0);
        checkOutput("gapped busy cycles", busy_cycles, 460);
        checkTable(1'b1, 1'b0, 1'b1);

        $display("[TB] Kyber NTT, start pulsed while busy");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, -1, 0, 100, 1'b0);

        $display("[TB] random back-pressure");
        for (int m = 0; m < 4; m++)
            applyStimulus(m[1], m[0], 1'b0, 1'b1, -1, 0, -1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, -1, 0, $urandom_range(1, 900), 1'b0);

        $display("[TB] asynchronous reset mid layer 3");
        use_gap = 1'b0;
        @(negedge clk);
        sel_kd = 1'b1; sel_ntt = 1'b1; ready = 1'b1; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        waited = 0;
        while (!(obs_valid && obs_layer == 3'd3) && waited < 600) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("reached layer 3", {obs_valid, obs_layer}, {1'b1, 3'd3});
        repeat (5) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        checkOutput("async reset outputs", obs_pack(), 64'd0);
        checkOutput("async reset done", obs_done, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("idle after reset {busy,valid}", {obs_busy, obs_valid}, 2'b00);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, -1, 0, -1, 1'b0);
        checkTable(1'b1, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
